// File: rtl/vga_tile_renderer_pkg.sv
// Shared constants, palette, pipeline control type and tile-index helper for the tile renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a; the renderer is a free-running pixel pipeline with no stall path.
package vga_pkg;

    localparam int TILE_W         = 16;
    localparam int TILE_H         = 16;
    localparam int MAP_COLS       = 40;
    localparam int MAP_ROWS       = 30;
    localparam int MAP_DEPTH      = MAP_COLS * MAP_ROWS;
    localparam int SCREEN_W       = MAP_COLS * TILE_W;
    localparam int SCREEN_H       = MAP_ROWS * TILE_H;
    localparam int RENDER_LATENCY = 3;

    typedef logic [11:0] rgb_t;

    // 16-colour palette as {R,G,B} nibbles; entry 0 is the background black.
    localparam rgb_t PALETTE [0:15] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // Per-pixel control carried alongside the map/glyph lookups.
    // vld means "visible and on-screen", so it alone decides whether RGB is drawn.
    typedef struct packed {
        logic       vld;
        logic       first;
        logic [3:0] sub_row;
        logic [3:0] sub_col;
        logic       h_sync;
        logic       v_sync;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_IDLE = '{
        vld:     1'b0,
        first:   1'b0,
        sub_row: 4'd0,
        sub_col: 4'd0,
        h_sync:  1'b1,
        v_sync:  1'b1
    };

    // tile_row*40 + tile_col using shift-add so no multiplier is inferred.
    function automatic logic [10:0] tile_index(input logic [4:0] tile_row,
                                               input logic [5:0] tile_col);
        logic [10:0] row11;
        row11 = {6'd0, tile_row};
        return (row11 << 5) + (row11 << 3) + {5'd0, tile_col};
    endfunction

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Bundle of timing, tile-map write, glyph ROM and pixel output signals of the tile renderer.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or driven every pixel clock.
interface vga_tile_renderer_if;

    logic        display_enable;
    logic [15:0] row;
    logic [15:0] column;
    logic        h_sync;
    logic        v_sync;

    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    logic [7:0]  glyph_addr;
    logic [15:0] glyph_data;

    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        frame_start;

    // master: timing stage, game logic and glyph ROM side.
    modport master (
        output display_enable, row, column, h_sync, v_sync,
        output wr_en, wr_addr, wr_data,
        output glyph_data,
        input  glyph_addr,
        input  red, green, blue, h_sync_out, v_sync_out, frame_start
    );

    // slave: the renderer.
    modport slave (
        input  display_enable, row, column, h_sync, v_sync,
        input  wr_en, wr_addr, wr_data,
        input  glyph_data,
        output glyph_addr,
        output red, green, blue, h_sync_out, v_sync_out, frame_start
    );

endinterface

// File: rtl/vga_tile_renderer_ram.sv
// Tile map, 1200 x 8: one synchronous write port, one synchronous read port returning old data on collision.
// Latency: read data valid 1 cycle after the read-enable edge; writes land in 1 cycle.
// Backpressure: none; out-of-range writes are silently dropped.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_en/i_rd_addr read request; o_rd_data registered read data.
module tile_map_ram
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [10:0] i_wr_addr,
    input  logic [7:0]  i_wr_data,
    input  logic        i_rd_en,
    input  logic [10:0] i_rd_addr,
    output logic [7:0]  o_rd_data
);

    logic [7:0] r_mem [0:MAP_DEPTH-1];
    logic [7:0] r_rd_data;
    logic       w_wr_ok;

    assign w_wr_ok = i_wr_en && (i_wr_addr < 11'(MAP_DEPTH));

    // Read and write share one block with non-blocking updates, so a same-cycle
    // read of the written address sees the previous contents.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vga_tile_renderer.sv
// 40x30 tile-map text/tile renderer: map lookup -> external glyph ROM -> palette, with syncs delayed to match.
// Latency: inputs sampled at edge N appear on RGB/syncs/frame_start after edge N+3.
// Backpressure: none; one pixel accepted and one produced every clock, map writes accepted every clock.
// Ports: clk, reset (sync, active-high); bus (slave) carries timing inputs, map write port,
//        glyph ROM address/data and the RGB, delayed sync and frame_start outputs.
module vga_tile_renderer
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    vga_tile_renderer_if.slave bus
);

    localparam int LAST = RENDER_LATENCY - 1;

    logic        w_in_range;
    logic        w_pix_vld;
    logic        w_wr_en;
    logic [10:0] w_rd_addr;
    logic [7:0]  w_rd_data;
    logic        w_bit;
    rgb_t        w_rgb_next;
    pix_ctl_t    w_ctl_in;

    // r_ctl[0] is aligned with map read data, r_ctl[1] with glyph_addr,
    // r_ctl[2] with glyph_data coming back from the ROM.
    pix_ctl_t    r_ctl [0:LAST];
    logic [3:0]  r_fg_s2;
    logic [3:0]  r_fg_s3;
    logic [7:0]  r_glyph_addr;
    rgb_t        r_rgb;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_frame_start;

    assign w_in_range = (bus.row < 16'(SCREEN_H)) && (bus.column < 16'(SCREEN_W));
    assign w_pix_vld  = bus.display_enable && w_in_range;
    assign w_rd_addr  = tile_index(bus.row[8:4], bus.column[9:4]);
    assign w_wr_en    = bus.wr_en && !reset;

    always_comb begin
        w_ctl_in         = PIX_CTL_IDLE;
        w_ctl_in.vld     = w_pix_vld;
        w_ctl_in.first   = bus.display_enable && (bus.row == 16'd0) && (bus.column == 16'd0);
        w_ctl_in.sub_row = bus.row[3:0];
        w_ctl_in.sub_col = bus.column[3:0];
        w_ctl_in.h_sync  = bus.h_sync;
        w_ctl_in.v_sync  = bus.v_sync;
    end

    // Read enable is gated by the range check, so off-screen coordinates never
    // address the map.
    tile_map_ram u_map (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_pix_vld),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Bit 15 is the leftmost pixel, so the bit index is 15 - sub_col == ~sub_col.
    assign w_bit = bus.glyph_data[~r_ctl[LAST].sub_col];

    always_comb begin
        w_rgb_next = '0;
        if (r_ctl[LAST].vld) begin
            w_rgb_next = w_bit ? PALETTE[r_fg_s3] : PALETTE[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= LAST; i++) begin
                r_ctl[i] <= PIX_CTL_IDLE;
            end
            r_fg_s2       <= '0;
            r_fg_s3       <= '0;
            r_glyph_addr  <= '0;
            r_rgb         <= '0;
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_ctl[0] <= w_ctl_in;
            for (int i = 1; i <= LAST; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
            // Idle ROM address for blank pixels keeps the ROM bus quiet.
            r_glyph_addr  <= r_ctl[0].vld ? {w_rd_data[3:0], r_ctl[0].sub_row} : 8'h00;
            r_fg_s2       <= w_rd_data[7:4];
            r_fg_s3       <= r_fg_s2;
            r_rgb         <= w_rgb_next;
            r_h_sync      <= r_ctl[LAST].h_sync;
            r_v_sync      <= r_ctl[LAST].v_sync;
            r_frame_start <= r_ctl[LAST].first;
        end
    end

    assign bus.glyph_addr  = r_glyph_addr;
    assign bus.red         = r_rgb[11:8];
    assign bus.green       = r_rgb[7:4];
    assign bus.blue        = r_rgb[3:0];
    assign bus.h_sync_out  = r_h_sync;
    assign bus.v_sync_out  = r_v_sync;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer: reference model of map, glyph ROM and palette.
// Latency: expectation for a vector driven before edge N is due just after edge N+3.
// Backpressure: none; the monitor checks one output per clock whenever an expectation is due.
module tb_vga_tile_renderer;

    logic clk;
    logic reset;

    vga_tile_renderer_if bus ();

    vga_tile_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        int          due;
        int          id;
    } exp_t;

    exp_t        exp_q [$];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_id   = 0;

    logic [7:0]  map [1200];
    logic [15:0] rom [256];
    logic [11:0] pal [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    always @(posedge clk) cyc <= cyc + 1;

    // External glyph ROM with one registered cycle of latency.
    always @(posedge clk) bus.glyph_data <= rom[bus.glyph_addr];

    function automatic exp_t model(input logic de, input logic [15:0] r, input logic [15:0] c,
                                   input logic hs, input logic vs);
        exp_t        e;
        int          ri;
        int          ci;
        logic [7:0]  ent;
        logic [15:0] bits;
        ri    = int'(r);
        ci    = int'(c);
        e.hs  = hs;
        e.vs  = vs;
        e.fs  = de && (ri == 0) && (ci == 0);
        e.rgb = 12'h000;
        e.due = 0;
        e.id  = 0;
        if (de && ri < 480 && ci < 640) begin
            ent   = map[(ri / 16) * 40 + ci / 16];
            bits  = rom[int'(ent[3:0]) * 16 + ri % 16];
            e.rgb = bits[15 - ci % 16] ? pal[ent[7:4]] : pal[0];
        end
        return e;
    endfunction

    task automatic apply(input logic rst, input logic de, input logic [15:0] r, input logic [15:0] c,
                         input logic hs, input logic vs, input logic we,
                         input logic [10:0] wa, input logic [7:0] wd);
        exp_t e;
        @(negedge clk);
        reset              = rst;
        bus.display_enable = de;
        bus.row            = r;
        bus.column         = c;
        bus.h_sync         = hs;
        bus.v_sync         = vs;
        bus.wr_en          = we;
        bus.wr_addr        = wa;
        bus.wr_data        = wd;
        e     = model(de, r, c, hs, vs);
        e.due = cyc + 4;
        e.id  = n_id;
        n_id++;
        if (rst) begin
            // Reset flushes everything still in flight and idles this vector too.
            foreach (exp_q[i]) begin
                exp_q[i].rgb = 12'h000;
                exp_q[i].hs  = 1'b1;
                exp_q[i].vs  = 1'b1;
                exp_q[i].fs  = 1'b0;
            end
            e.rgb = 12'h000;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.fs  = 1'b0;
        end
        exp_q.push_back(e);
        if (!rst && we && int'(wa) < 1200) map[wa] = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops and compares whenever an expectation falls due.
    initial begin : monitor
        exp_t e;
        logic [11:0] act_rgb;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed vector %0d: due cycle %0d, now %0d", e.id, e.due, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                act_rgb = {bus.red, bus.green, bus.blue};
                n_vec++;
                if (act_rgb !== e.rgb || bus.h_sync_out !== e.hs ||
                    bus.v_sync_out !== e.vs || bus.frame_start !== e.fs) begin
                    n_err++;
                    $display("FAIL pixel vector %0d: got rgb=%h hs=%b vs=%b fs=%b, expected rgb=%h hs=%b vs=%b fs=%b",
                             e.id, act_rgb, bus.h_sync_out, bus.v_sync_out, bus.frame_start,
                             e.rgb, e.hs, e.vs, e.fs);
                end
            end
        end
    end

    initial begin : stim
        logic        de;
        logic [15:0] r;
        logic [15:0] c;
        logic        hs;
        logic        vs;
        logic        we;
        logic [10:0] wa;
        logic [7:0]  wd;
        logic [3:0]  seq;

        reset              = 1'b1;
        bus.display_enable = 1'b0;
        bus.row            = '0;
        bus.column         = '0;
        bus.h_sync         = 1'b1;
        bus.v_sync         = 1'b1;
        bus.wr_en          = 1'b0;
        bus.wr_addr        = '0;
        bus.wr_data        = '0;

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[16] = 16'h8000;                          // glyph 1, row 0
        for (int i = 0; i < 16; i++) rom[240 + i] = 16'hFFFF;   // glyph 15 solid
        for (int i = 0; i < 1200; i++) map[i] = 8'h00;

        // Reset state.
        repeat (3) apply(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 11'd0, 8'h00);
        chk("reset_rgb",         {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
        chk("reset_h_sync_out",  {31'd0, bus.h_sync_out}, 32'd1);
        chk("reset_v_sync_out",  {31'd0, bus.v_sync_out}, 32'd1);
        chk("reset_frame_start", {31'd0, bus.frame_start}, 32'd0);
        chk("reset_glyph_addr",  {24'd0, bus.glyph_addr}, 32'd0);

        // Fill the map while blanked; RGB must stay black throughout.
        for (int t = 0; t < 1200; t++) begin
            wd = 8'($urandom);
            if (t == 0)  wd = 8'hF1;
            if (t == 41) wd = 8'h3F;
            apply(1'b0, 1'b0, 16'($urandom_range(0, 479)), 16'($urandom_range(0, 639)),
                  1'($urandom), 1'($urandom), 1'b1, 11'(t), wd);
        end

        // Blanked pixels over a solid-glyph, white tile.
        apply(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 11'd2, 8'hFF);
        for (int i = 0; i < 16; i++)
            apply(1'b0, 1'b0, 16'(i), 16'(32 + i), 1'b1, 1'b1, 1'b0, 11'd0, 8'h00);

        // Top-left pixel: white with frame_start, then its right neighbour black.
        apply(1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 11'd0, 8'h00);
        apply(1'b0, 1'b1, 16'd0, 16'd1, 1'b1, 1'b1, 1'b0, 11'd0, 8'h00);

        // Sync pattern 1,0,0,1 on both syncs.
        seq = 4'b1001;
        for (int i = 3; i >= 0; i--)
            apply(1'b0, 1'b0, 16'd0, 16'd0, seq[i], seq[i], 1'b0, 11'd0, 8'h00);

        // Same-cycle write and read of tile 41: old entry, then new entry.
        apply(1'b0, 1'b1, 16'd16, 16'd16, 1'b1, 1'b1, 1'b1, 11'd41, 8'h21);
        apply(1'b0, 1'b1, 16'd16, 16'd16, 1'b1, 1'b1, 1'b0, 11'd0, 8'h00);

        // Out-of-range writes, then read back one pixel of every tile.
        apply(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 11'd1200, 8'hFF);
        apply(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 11'd2047, 8'hFF);
        for (int t = 0; t < 1200; t++)
            apply(1'b0, 1'b1, 16'((t / 40) * 16 + $urandom_range(0, 15)),
                  16'((t % 40) * 16 + $urandom_range(0, 15)), 1'b1, 1'b1, 1'b0, 11'd0, 8'h00);

        // Random traffic with a one-cycle reset (carrying a write) in the middle.
        for (int i = 0; i < 2500; i++) begin
            de = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 479));
            c  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 639));
            if ($urandom_range(0, 63) == 0) begin
                r = 16'd0;
                c = 16'd0;
            end
            hs = ($urandom_range(0, 7) != 0);
            vs = ($urandom_range(0, 7) != 0);
            we = 1'($urandom);
            wa = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 1199));
            wd = 8'($urandom);
            if (i >= 1204 && i < 1212) begin
                de = 1'b1;
                r  = 16'($urandom_range(0, 15));
                c  = 16'(112 + $urandom_range(0, 15));
                we = 1'b0;
            end
            apply((i == 1200) ? 1'b1 : 1'b0, de, r, c, hs, vs,
                  (i == 1200) ? 1'b1 : we, (i == 1200) ? 11'd7 : wa,
                  (i == 1200) ? 8'h99 : wd);
        end

        // Drain, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        n_vec++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: pixel clock; the only clock.
- reset, in, 1: synchronous, active-high reset.
- display_enable, in, 1: visible-area flag from the VGA timing stage.
- row, in, 16: visible row, 0..479.
- column, in, 16: visible column, 0..639.
- h_sync, in, 1: horizontal sync from the timing stage, active-low.
- v_sync, in, 1: vertical sync from the timing stage, active-low.
- wr_en, in, 1: tile-map write strobe from game logic.
- wr_addr, in, 11: tile index, 0..1199, equal to tile_row*40 + tile_col.
- wr_data, in, 8: tile entry; [7:4] foreground palette index, [3:0] glyph code.
- glyph_addr, out, 8: external glyph ROM address, {glyph code, pixel row within tile}.
- glyph_data, in, 16: glyph ROM row bitmap, 1-cycle registered latency; bit 15 = leftmost pixel.
- red, out, 4: pixel colour, red channel.
- green, out, 4: pixel colour, green channel.
- blue, out, 4: pixel colour, blue channel.
- h_sync_out, out, 1: h_sync delayed to align with RGB.
- v_sync_out, out, 1: v_sync delayed to align with RGB.
- frame_start, out, 1: one-cycle pulse when pixel (0,0) is output.

REQ-002 One clock (clk); reset is synchronous and active-high (reset).

Function
REQ-003 Screen SHALL be a 40x30 grid of 16x16-pixel tiles: tile_col = column[9:4], tile_row = row[8:4].
REQ-004 Pipeline SHALL be 3 stages; inputs sampled at edge N produce RGB, syncs and frame_start at the outputs after edge N+3.
- S1: register inputs; read the tile map at tile_row*40 + tile_col.
- S2: drive glyph_addr = {glyph code, row[3:0]}.
- S3: select bit (15 - column[3:0]) of glyph_data; register the RGB.
REQ-005 Selected bit 1 SHALL output palette[fg index]; bit 0 SHALL output palette[0].
REQ-006 RGB SHALL be forced to 0 whenever the delayed display_enable is 0, regardless of the tile map.
REQ-007 h_sync_out and v_sync_out SHALL equal h_sync and v_sync delayed exactly 3 cycles, with no glitch or reshaping.
REQ-008 frame_start SHALL be 1 for exactly one cycle, aligned with the output of the pixel sampled with display_enable=1, row=0, column=0.
REQ-009 Tile-map writes SHALL complete in one cycle when wr_en=1, and are accepted in any cycle including the visible area.
REQ-010 Writes with wr_addr >= 1200 SHALL be ignored, leaving the map unchanged.
REQ-011 On a same-cycle read and write to one address, the read SHALL return the old data; the new data is visible from the next cycle.
REQ-012 Inputs with column >= 640 or row >= 480 while display_enable=1 SHALL produce RGB 0 and perform no out-of-range map read.
REQ-013 Address arithmetic SHALL be 11-bit unsigned; tile_row*40 is formed as (tile_row<<5)+(tile_row<<3).

Reset
REQ-014 While reset=1 at an edge, the following SHALL clear:
- red, green, blue = 0
- h_sync_out = v_sync_out = 1 (idle)
- frame_start = 0
- glyph_addr = 0
- all pipeline valid and delay registers
REQ-015 Tile-map contents SHALL NOT be altered by reset; power-up contents are all 0.
REQ-016 Reset mid-line SHALL suppress outputs for the 3 cycles after release, until the pipeline refills; output then resumes with no stale frame_start.
REQ-017 wr_en SHALL be ignored while reset=1.

Structure
REQ-018 Shared package vga_pkg SHALL hold:
- TILE_W = 16, TILE_H = 16, MAP_COLS = 40, MAP_ROWS = 30
- RENDER_LATENCY = 3
- the 16-entry 12-bit palette constant (entry 0 = black, 15 = white)
REQ-019 The tile map SHALL be a sub-module tile_map_ram: 1200x8, one synchronous write port, one synchronous read port, read-old-data behaviour.

Verification
REQ-020 Scenario: tile 0 = 8'hF1, glyph 1 row 0 = 16'h8000, input row=0, column=0, display_enable=1 -> 3 cycles later RGB = 12'hFFF and frame_start=1; column=1 -> RGB=0.
REQ-021 Scenario: toggle h_sync 1,0,0,1 on consecutive cycles -> h_sync_out shows 1,0,0,1 starting 3 cycles later; same for v_sync.
REQ-022 Scenario: display_enable=0 with tile data all 8'hFF and glyph all-ones -> RGB=0 for every such input cycle.
REQ-023 Scenario: write 8'h21 to addr 41 while reading addr 41 in the same cycle -> old entry rendered; next read of tile (1,1) uses palette[2].
REQ-024 Scenario: write 8'hFF to addr 1200 and 2047 -> addr 0..1199 unchanged (verified by full-frame readback).
REQ-025 Scenario: assert reset for 1 cycle mid-frame -> next edge RGB=0, syncs=1, frame_start=0; correct output from the 4th cycle after release.
